// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: column scan, 2-flop row sync, frame debounce,
// 4-entry key FIFO read by the CPU through a DATA/STATUS register window.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV = 16,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       read,
    input  logic       address,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic [3:0] col,
    input  logic [3:0] row,
    output logic       irq
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESS   = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic [3:0]       row_s1_q, row_s2_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [3:0]       col_q, col_d;
    logic             hit_q, hit_d;
    logic [3:0]       code_q, code_d;
    logic [1:0]       state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       mem_q [4];
    logic [3:0]       mem_d [4];
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0]       rd_ptr_q, rd_ptr_d;
    logic [2:0]       count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             acc_q, acc_d;
    logic             irq_q, irq_d;

    logic       slot_end_c, frame_end_c;
    logic       col_hit_c;
    logic [1:0] col_row_c;
    logic [3:0] sample_code_c;
    logic       res_hit_c;
    logic [3:0] res_code_c;
    logic       push_c, pop_req_c, acc_c, wr_c, flush_c, ovf_clr_c;
    logic       do_push_c, do_pop_c, ovf_set_c;
    logic       unused_din_c;

    assign unused_din_c = ^{din[7:6], din[4:1]};

    // Lowest synced row bit that is low in the column being sampled
    always_comb begin
        col_hit_c = 1'b0;
        col_row_c = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_s2_q[r]) begin
                col_hit_c = 1'b1;
                col_row_c = 2'(r);
            end
        end
    end

    assign sample_code_c = {col_row_c, col_idx_q};
    assign slot_end_c    = (div_q == DIV_LAST);
    assign frame_end_c   = slot_end_c && (col_idx_q == 2'd3);
    assign res_hit_c     = hit_q | col_hit_c;
    assign res_code_c    = hit_q ? code_q : sample_code_c;

    // Column scan and frame-result accumulation
    always_comb begin
        div_d     = slot_end_c ? '0 : div_q + DIV_W'(1);
        col_idx_d = slot_end_c ? col_idx_q + 2'd1 : col_idx_q;
        col_d     = ~(4'b0001 << col_idx_d);
        hit_d     = hit_q;
        code_d    = code_q;
        if (frame_end_c) begin
            hit_d  = 1'b0;
            code_d = 4'd0;
        end else if (slot_end_c && !hit_q && col_hit_c) begin
            hit_d  = 1'b1;
            code_d = sample_code_c;
        end
    end

    // Debounce FSM, evaluated only on the frame-end clock
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        push_c  = 1'b0;
        if (frame_end_c) begin
            case (state_q)
                ST_IDLE: begin
                    if (res_hit_c) begin
                        cand_d = res_code_c;
                        cnt_d  = CNT_ONE;
                        if (CNT_ONE == CNT_MAX) begin
                            state_d = ST_HELD;
                            push_c  = 1'b1;
                        end else begin
                            state_d = ST_PRESS;
                        end
                    end
                end
                ST_PRESS: begin
                    if (res_hit_c && (res_code_c == cand_q)) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_q + CNT_ONE == CNT_MAX) begin
                            state_d = ST_HELD;
                            push_c  = 1'b1;
                        end
                    end else if (!res_hit_c) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cand_d = res_code_c;
                        cnt_d  = CNT_ONE;
                        if (CNT_ONE == CNT_MAX) begin
                            state_d = ST_HELD;
                            push_c  = 1'b1;
                        end
                    end
                end
                ST_HELD: begin
                    if (!res_hit_c) begin
                        cnt_d   = CNT_ONE;
                        state_d = (CNT_ONE == CNT_MAX) ? ST_IDLE : ST_RELEASE;
                    end
                end
                default: begin
                    if (!res_hit_c) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_q + CNT_ONE == CNT_MAX) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_HELD;
                    end
                end
            endcase
        end
    end

    assign acc_c     = cs & read & ~address;
    assign acc_d     = acc_c;
    assign pop_req_c = acc_c & ~acc_q;
    assign wr_c      = cs & ~read & address;
    assign flush_c   = wr_c & din[0];
    assign ovf_clr_c = wr_c & din[5];

    // A pop in the same cycle frees a slot for a push into a full FIFO
    assign do_pop_c  = ~flush_c & pop_req_c & (count_q != 3'd0);
    assign do_push_c = ~flush_c & push_c & ((count_q != 3'd4) | do_pop_c);
    assign ovf_set_c = ~flush_c & push_c & ~do_push_c;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (flush_c) begin
            wr_ptr_d = 2'd0;
            rd_ptr_d = 2'd0;
            count_d  = 3'd0;
        end else begin
            if (do_push_c) begin
                mem_d[wr_ptr_q] = cand_q;
                wr_ptr_d        = wr_ptr_q + 2'd1;
            end
            if (do_pop_c) begin
                rd_ptr_d = rd_ptr_q + 2'd1;
            end
            count_d = count_q + {2'b00, do_push_c} - {2'b00, do_pop_c};
        end
        if (ovf_clr_c) begin
            ovf_d = 1'b0;
        end
        if (ovf_set_c) begin
            ovf_d = 1'b1;
        end
        irq_d = (count_d != 3'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1_q  <= 4'hF;
            row_s2_q  <= 4'hF;
            div_q     <= '0;
            col_idx_q <= 2'd0;
            col_q     <= 4'b1110;
            hit_q     <= 1'b0;
            code_q    <= 4'd0;
            state_q   <= ST_IDLE;
            cand_q    <= 4'd0;
            cnt_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= 4'd0;
            end
            wr_ptr_q  <= 2'd0;
            rd_ptr_q  <= 2'd0;
            count_q   <= 3'd0;
            ovf_q     <= 1'b0;
            acc_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            row_s1_q  <= row;
            row_s2_q  <= row_s1_q;
            div_q     <= div_d;
            col_idx_q <= col_idx_d;
            col_q     <= col_d;
            hit_q     <= hit_d;
            code_q    <= code_d;
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            acc_q     <= acc_d;
            irq_q     <= irq_d;
        end
    end

    // Register window; dout is combinational from registers
    always_comb begin
        dout = 8'h00;
        if (cs) begin
            if (address) begin
                dout = {(count_q == 3'd0), (count_q == 3'd4), ovf_q,
                        state_q[1], 1'b0, count_q};
            end else if (count_q == 3'd0) begin
                dout = 8'hFF;
            end else begin
                dout = {4'h0, mem_q[rd_ptr_q]};
            end
        end
    end

    assign col = col_q;
    assign irq = irq_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: directed key patterns, expected bus
// reads queued by the stimulus and checked by an independent monitor.
module tb_keypad_scanner;

    localparam int FRAME = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs;
    logic       read;
    logic       address;
    logic [7:0] din;
    logic [7:0] dout;
    logic [3:0] col;
    logic [3:0] row;
    logic       irq;

    logic       key_on;
    logic [3:0] key_code;

    int checks   = 0;
    int failures = 0;
    int cyc;

    string      name_q[$];
    logic [7:0] edout_q[$];
    logic       eirq_q[$];
    logic       echk_q[$];

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk(clk), .rst(rst), .cs(cs), .read(read), .address(address),
        .din(din), .dout(dout), .col(col), .row(row), .irq(irq)
    );

    // Keypad matrix: pressed key pulls its row low while its column is driven
    always_comb begin
        row = 4'hF;
        if (key_on && !col[key_code[1:0]]) row[key_code[3:2]] = 1'b0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Monitor: every bus read cycle consumes one queued expectation
    always @(negedge clk) begin : monitor
        string      n;
        logic [7:0] ed;
        logic       ei;
        logic       ec;
        if (cs && read) begin
            checks++;
            if (name_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_read: dout=%h irq=%b with no expectation queued", dout, irq);
            end else begin
                n  = name_q.pop_front();
                ed = edout_q.pop_front();
                ei = eirq_q.pop_front();
                ec = echk_q.pop_front();
                if (dout !== ed || irq !== ei || (ec && col !== 4'b1110)) begin
                    failures++;
                    $display("FAIL %s: got dout=%h irq=%b col=%b, expected dout=%h irq=%b col=%s",
                             n, dout, irq, col, ed, ei, ec ? "1110" : "any");
                end
            end
        end
    end

    task automatic expect_rd(input string n, input logic [7:0] d, input logic i,
                             input logic c = 1'b0);
        name_q.push_back(n);
        edout_q.push_back(d);
        eirq_q.push_back(i);
        echk_q.push_back(c);
    endtask

    task automatic bus_read(input logic a, input string n, input logic [7:0] d,
                            input logic i, input logic c = 1'b0);
        expect_rd(n, d, i, c);
        address = a;
        cs      = 1'b1;
        read    = 1'b1;
        @(posedge clk); #1;
        cs   = 1'b0;
        read = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic bus_write(input logic [7:0] v);
        address = 1'b1;
        read    = 1'b0;
        din     = v;
        cs      = 1'b1;
        @(posedge clk); #1;
        cs  = 1'b0;
        din = 8'h00;
        @(posedge clk); #1;
    endtask

    // Advance to just after the n-th following frame-end edge
    task automatic wait_frames(input int n);
        for (int k = 0; k < n; k++) begin
            do begin
                @(posedge clk); #1;
            end while (cyc % FRAME != 0);
        end
    endtask

    task automatic press(input logic [3:0] c);
        key_code = c;
        key_on   = 1'b1;
    endtask

    task automatic release_key();
        key_on = 1'b0;
    endtask

    initial begin
        logic [3:0] keys [5];
        keys[0] = 4'h0; keys[1] = 4'h3; keys[2] = 4'hC; keys[3] = 4'hF; keys[4] = 4'h7;

        rst = 1'b1; cs = 1'b0; read = 1'b0; address = 1'b0; din = 8'h00;
        key_on = 1'b0; key_code = 4'h0;
        repeat (3) @(posedge clk); #1;
        bus_read(1'b1, "reset_status", 8'h80, 1'b0, 1'b1);
        bus_read(1'b0, "reset_data", 8'hFF, 1'b0, 1'b1);
        rst = 1'b0;

        // 1: key 9 qualifies after three frames
        press(4'h9);
        wait_frames(3);
        bus_read(1'b1, "t1_status_after_push", 8'h11, 1'b1);
        wait_frames(2);
        release_key();
        wait_frames(3);
        bus_read(1'b0, "t1_data", 8'h09, 1'b1);
        bus_read(1'b1, "t1_status_empty", 8'h80, 1'b0);
        bus_read(0, "t1_data_empty", 8'hFF, 1'b0);

        // 2: two-frame bounces never qualify
        wait_frames(1);
        for (int k = 0; k < 4; k++) begin
            press(4'h5);
            wait_frames(2);
            release_key();
            wait_frames(1);
        end
        bus_read(1'b1, "t2_status_bounce", 8'h80, 1'b0);

        // 3: five presses overflow the four-entry FIFO
        wait_frames(1);
        for (int k = 0; k < 5; k++) begin
            press(keys[k]);
            wait_frames(4);
            release_key();
            wait_frames(4);
        end
        bus_read(1'b1, "t3_status_full_ovf", 8'h64, 1'b1);
        bus_read(1'b0, "t3_data0", 8'h00, 1'b1);
        bus_read(1'b0, "t3_data1", 8'h03, 1'b1);
        bus_read(1'b0, "t3_data2", 8'h0C, 1'b1);
        bus_read(1'b0, "t3_data3", 8'h0F, 1'b1);
        bus_read(1'b1, "t3_status_ovf_only", 8'hA0, 1'b0);
        bus_write(8'h20);
        bus_read(1'b1, "t3_status_ovf_cleared", 8'h80, 1'b0);

        // 4: long hold pushes once; short release does not re-arm
        wait_frames(1);
        press(4'hA);
        wait_frames(20);
        bus_read(1'b1, "t4_status_long_hold", 8'h11, 1'b1);
        wait_frames(1);
        release_key();
        wait_frames(3);
        press(4'hA);
        wait_frames(3);
        bus_read(1'b1, "t4_status_second_push", 8'h12, 1'b1);
        wait_frames(1);
        release_key();
        wait_frames(2);
        press(4'hA);
        wait_frames(4);
        release_key();
        wait_frames(4);
        bus_read(1'b1, "t4_status_no_third", 8'h02, 1'b1);
        bus_read(1'b0, "t4_data_a", 8'h0A, 1'b1);
        wait_frames(1);
        press(4'h3);
        wait_frames(3);
        release_key();
        wait_frames(4);
        bus_read(1'b1, "t4_status_two_queued", 8'h02, 1'b1);

        // 5: held DATA read whose first edge coincides with a push
        wait_frames(1);
        press(4'h5);
        wait_frames(2);
        repeat (15) @(posedge clk);
        #1;
        expect_rd("t5_hold_first", 8'h0A, 1'b1);
        for (int k = 0; k < 5; k++) expect_rd("t5_hold_after_pop", 8'h03, 1'b1);
        address = 1'b0;
        cs      = 1'b1;
        read    = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        cs   = 1'b0;
        read = 1'b0;
        @(posedge clk); #1;
        bus_read(1'b1, "t5_status_count2", 8'h12, 1'b1);
        wait_frames(1);
        release_key();
        wait_frames(3);
        bus_read(1'b0, "t5_data_3", 8'h03, 1'b1);
        bus_read(1'b1, "t5_status_one", 8'h01, 1'b1);

        // 6: reset mid-debounce, then full requalification and flush
        wait_frames(1);
        press(4'h6);
        wait_frames(2);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        bus_read(1'b1, "t6_reset_status", 8'h80, 1'b0, 1'b1);
        rst = 1'b0;
        wait_frames(2);
        bus_read(1'b1, "t6_no_early_push", 8'h80, 1'b0);
        wait_frames(1);
        bus_read(1'b1, "t6_requalified", 8'h11, 1'b1);
        bus_write(8'h01);
        bus_read(1'b1, "t6_flushed_status", 8'h90, 1'b0);
        bus_read(1'b0, "t6_flushed_data", 8'hFF, 1'b0);
        release_key();
        repeat (4) @(posedge clk);

        checks++;
        if (name_q.size() != 0) begin
            failures++;
            $display("FAIL pending_expectations: got %0d unconsumed, expected 0", name_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
